// File: rtl/thread_msg_pkg.sv
// ============================================================================
// Module : thread_msg_pkg
// Brief  : Message codes, dispatcher FSM states and slot record shared by the
//          thread dispatch table and its arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package thread_msg_pkg;

  localparam logic [7:0] MSG_NONE  = 8'h00;
  localparam logic [7:0] FORK_THRD = 8'h10;
  localparam logic [7:0] FORK_DONE = 8'h11;
  localparam logic [7:0] STOP_THRD = 8'h12;
  localparam logic [7:0] STOP_DONE = 8'h13;
  localparam logic [7:0] NACK      = 8'h1F;

  // Slot fields are sized for the widest supported address; narrower builds
  // zero-extend on write and truncate on read.
  localparam int SLOT_ADDR_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_ALLOC    = 3'd2,
    ST_SEARCH   = 3'd3,
    ST_ACK      = 3'd4,
    ST_WAIT_CLR = 3'd5
  } disp_state_t;

  typedef struct packed {
    logic                   valid;
    logic [SLOT_ADDR_W-1:0] addr;
    logic [SLOT_ADDR_W-1:0] data;
  } slot_t;

endpackage

`default_nettype wire

// File: rtl/thread_dispatch_table_if.sv
// ============================================================================
// Module : thread_dispatch_table_if
// Brief  : Thread-controller and scheduler signal bundle of the dispatcher.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface thread_dispatch_table_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              disp_online;
  logic [7:0]        req_code;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_data;
  logic [7:0]        ack_code;
  logic              sched_req;
  logic              sched_valid;
  logic [ADDR_W-1:0] sched_addr;
  logic [ADDR_W-1:0] sched_data;
  logic [CNT_W-1:0]  thread_cnt;

  modport master (
    input  disp_online, ack_code, sched_valid, sched_addr, sched_data, thread_cnt,
    output req_code, req_addr, req_data, sched_req
  );

  modport slave (
    output disp_online, ack_code, sched_valid, sched_addr, sched_data, thread_cnt,
    input  req_code, req_addr, req_data, sched_req
  );

endinterface

`default_nettype wire

// File: rtl/thread_rr_arbiter.sv
// ============================================================================
// Module : thread_rr_arbiter
// Brief  : Round-robin pick of the first set request bit strictly after the
//          last granted index, wrapping DEPTH-1 -> 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module thread_rr_arbiter #(
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] grant,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Walk from farthest to nearest so the nearest requester wins; the last
  // granted index itself (offset DEPTH) carries the lowest priority.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = DEPTH; i >= 1; i--) begin
      cand = last + IDX_W'(i);
      if (req[cand]) begin
        grant = cand;
        any   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/thread_dispatch_table.sv
// ============================================================================
// Module : thread_dispatch_table
// Brief  : Thread slot table with fork/stop message handshake and round-robin
//          scheduler read-out. Optional THREAD_DISPATCH_STATS_EN adds reply
//          counters fork_total / stop_total / nack_total.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module thread_dispatch_table
  import thread_msg_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic clk,
  input  logic rst,
  thread_dispatch_table_if.slave bus
`ifdef THREAD_DISPATCH_STATS_EN
  ,
  output logic [15:0] fork_total,
  output logic [15:0] stop_total,
  output logic [15:0] nack_total
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  disp_state_t       state, state_nx;
  slot_t             tbl [DEPTH];
  logic [DEPTH-1:0]  valid_vec;
  logic [7:0]        lat_code;
  logic [ADDR_W-1:0] lat_addr;
  logic [ADDR_W-1:0] lat_data;
  logic [CNT_W-1:0]  scan_idx, scan_idx_nx;
  logic [7:0]        result, result_nx;
  logic [7:0]        ack_r, ack_nx;
  logic              need_clr;
  logic              accept;
  logic              wr_en;
  logic              clr_en;
  logic              scan_hit;
  logic [IDX_W-1:0]  free_idx;
  logic              free_any;
  logic [CNT_W-1:0]  cnt_nx;
  logic [CNT_W-1:0]  cnt_r;
  logic              online_r;
  logic [IDX_W-1:0]  rr_last;
  logic [IDX_W-1:0]  rr_grant;
  logic              rr_any;
  logic              sched_valid_r;
  logic [ADDR_W-1:0] sched_addr_r;
  logic [ADDR_W-1:0] sched_data_r;

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_valid
      assign valid_vec[g] = tbl[g].valid;
    end
  endgenerate

  always_comb begin
    free_idx = '0;
    free_any = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_idx = IDX_W'(i);
        free_any = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_nx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nx = cnt_nx + CNT_W'(valid_vec[i]);
    end
  end

  assign scan_hit = (scan_idx != CNT_W'(DEPTH)) &&
                    tbl[scan_idx[IDX_W-1:0]].valid &&
                    (tbl[scan_idx[IDX_W-1:0]].addr == SLOT_ADDR_W'(lat_addr));

  // A request is taken only once the controller has shown 00 since the last
  // handshake or reset, so a held message is never processed twice.
  assign accept = !need_clr &&
                  ((bus.req_code == FORK_THRD) || (bus.req_code == STOP_THRD));

  always_comb begin
    state_nx    = state;
    scan_idx_nx = scan_idx;
    result_nx   = result;
    ack_nx      = ack_r;
    wr_en       = 1'b0;
    clr_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nx = ST_LATCH;
      end
      ST_LATCH: begin
        scan_idx_nx = '0;
        state_nx    = (lat_code == FORK_THRD) ? ST_ALLOC : ST_SEARCH;
      end
      ST_ALLOC: begin
        wr_en     = free_any;
        result_nx = free_any ? FORK_DONE : NACK;
        state_nx  = ST_ACK;
      end
      ST_SEARCH: begin
        if (scan_idx == CNT_W'(DEPTH)) begin
          result_nx = NACK;
          state_nx  = ST_ACK;
        end else if (scan_hit) begin
          clr_en    = 1'b1;
          result_nx = STOP_DONE;
          state_nx  = ST_ACK;
        end else begin
          scan_idx_nx = scan_idx + 1'b1;
        end
      end
      ST_ACK: begin
        ack_nx   = result;
        state_nx = ST_WAIT_CLR;
      end
      ST_WAIT_CLR: begin
        if (bus.req_code == MSG_NONE) begin
          ack_nx   = MSG_NONE;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      scan_idx <= '0;
      result   <= MSG_NONE;
      ack_r    <= MSG_NONE;
      need_clr <= 1'b1;
      online_r <= 1'b0;
      lat_code <= MSG_NONE;
      lat_addr <= '0;
      lat_data <= '0;
    end else begin
      state    <= state_nx;
      scan_idx <= scan_idx_nx;
      result   <= result_nx;
      ack_r    <= ack_nx;
      online_r <= (state_nx == ST_IDLE);
      if (bus.req_code == MSG_NONE) need_clr <= 1'b0;
      else if (state == ST_IDLE && accept) need_clr <= 1'b1;
      if (state == ST_IDLE && accept) begin
        lat_code <= bus.req_code;
        lat_addr <= bus.req_addr;
        lat_data <= bus.req_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i].valid <= 1'b0;
      cnt_r <= '0;
    end else begin
      if (wr_en) begin
        tbl[free_idx] <= '{valid: 1'b1,
                           addr:  SLOT_ADDR_W'(lat_addr),
                           data:  SLOT_ADDR_W'(lat_data)};
      end
      if (clr_en) tbl[scan_idx[IDX_W-1:0]].valid <= 1'b0;
      cnt_r <= cnt_nx;
    end
  end

  thread_rr_arbiter #(.DEPTH(DEPTH)) u_rr (
    .req   (valid_vec),
    .last  (rr_last),
    .grant (rr_grant),
    .any   (rr_any)
  );

  // Selection reads the table as registered, i.e. before any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last       <= IDX_W'(DEPTH - 1);
      sched_valid_r <= 1'b0;
      sched_addr_r  <= '0;
      sched_data_r  <= '0;
    end else begin
      sched_valid_r <= bus.sched_req && rr_any;
      if (bus.sched_req && rr_any) begin
        rr_last      <= rr_grant;
        sched_addr_r <= ADDR_W'(tbl[rr_grant].addr);
        sched_data_r <= ADDR_W'(tbl[rr_grant].data);
      end
    end
  end

`ifdef THREAD_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fork_total <= '0;
      stop_total <= '0;
      nack_total <= '0;
    end else if (state == ST_ACK) begin
      if (result == FORK_DONE && fork_total != 16'hFFFF) fork_total <= fork_total + 1'b1;
      if (result == STOP_DONE && stop_total != 16'hFFFF) stop_total <= stop_total + 1'b1;
      if (result == NACK      && nack_total != 16'hFFFF) nack_total <= nack_total + 1'b1;
    end
  end
`endif

  assign bus.disp_online = online_r;
  assign bus.ack_code    = ack_r;
  assign bus.sched_valid = sched_valid_r;
  assign bus.sched_addr  = sched_addr_r;
  assign bus.sched_data  = sched_data_r;
  assign bus.thread_cnt  = cnt_r;

endmodule

`default_nettype wire

// File: tb/tb_thread_dispatch_table.sv
// ============================================================================
// Module : tb_thread_dispatch_table
// Brief  : Directed self-checking bench for thread_dispatch_table (DEPTH 8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_thread_dispatch_table;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors    = 0;
  int   miscompares = 0;

  thread_dispatch_table_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

`ifdef THREAD_DISPATCH_STATS_EN
  logic [15:0] fork_total, stop_total, nack_total;
`endif

  thread_dispatch_table #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef THREAD_DISPATCH_STATS_EN
    ,
    .fork_total (fork_total),
    .stop_total (stop_total),
    .nack_total (nack_total)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_code  = 8'h00;
    bus.sched_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Issue one message, measure edges from the sampling edge to ack, release.
  task automatic do_req(input logic [7:0] code, input logic [31:0] addr,
                        input logic [31:0] data, input logic [7:0] exp_ack,
                        input int exp_lat, input string tag);
    int lat;
    bus.req_code = code;
    bus.req_addr = addr;
    bus.req_data = data;
    tick();
    lat = 0;
    while (bus.ack_code === 8'h00 && lat < 60) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " ack"}, 64'(bus.ack_code), 64'(exp_ack));
    bus.req_code = 8'h00;
    tick();
    tick();
    chk({tag, " ack cleared"}, 64'(bus.ack_code), 64'h0);
  endtask

  task automatic sched_pulse(input logic exp_valid, input logic [31:0] exp_addr,
                             input string tag);
    bus.sched_req = 1'b1;
    tick();
    bus.sched_req = 1'b0;
    chk({tag, " valid"}, 64'(bus.sched_valid), 64'(exp_valid));
    if (exp_valid) chk({tag, " addr"}, 64'(bus.sched_addr), 64'(exp_addr));
    tick();
    chk({tag, " valid drop"}, 64'(bus.sched_valid), 64'h0);
  endtask

  initial begin
    bus.req_code  = 8'h00;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.sched_req = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst online", 64'(bus.disp_online), 64'h0);
    chk("rst ack", 64'(bus.ack_code), 64'h0);
    chk("rst sched_valid", 64'(bus.sched_valid), 64'h0);
    chk("rst sched_addr", 64'(bus.sched_addr), 64'h0);
    chk("rst thread_cnt", 64'(bus.thread_cnt), 64'h0);
    rst = 1'b0;
    tick();
    chk("online after rst", 64'(bus.disp_online), 64'h1);

    // First fork lands in slot 0
    do_req(8'h10, 32'h100, 32'h200, 8'h11, 3, "fork0");
    chk("fork0 cnt", 64'(bus.thread_cnt), 64'h1);
    chk("fork0 slot0 valid", 64'(dut.tbl[0].valid), 64'h1);
    sched_pulse(1'b1, 32'h100, "fork0 sched");
    chk("fork0 sched data", 64'(bus.sched_data), 64'h200);

    // Fill the table, then overflow
    for (int i = 1; i < 8; i++)
      do_req(8'h10, 32'h100 + 32'(i) * 32'h4, 32'h0, 8'h11, 3, "fill");
    chk("full cnt", 64'(bus.thread_cnt), 64'h8);
    do_req(8'h10, 32'h900, 32'h0, 8'h1F, 3, "fork9");
    chk("overflow cnt", 64'(bus.thread_cnt), 64'h8);
`ifdef THREAD_DISPATCH_STATS_EN
    chk("fork_total", 64'(fork_total), 64'h8);
    chk("nack_total", 64'(nack_total), 64'h1);
`endif

    // Stop hit at index 1, stop miss, duplicate handling
    do_reset();
    do_req(8'h10, 32'h100, 32'h0, 8'h11, 3, "fA");
    do_req(8'h10, 32'h140, 32'h0, 8'h11, 3, "fB");
    do_req(8'h10, 32'h180, 32'h0, 8'h11, 3, "fC");
    do_req(8'h12, 32'h140, 32'h0, 8'h13, 4, "stop140");
    chk("stop140 cnt", 64'(bus.thread_cnt), 64'h2);
    do_req(8'h12, 32'h999, 32'h0, 8'h1F, 3 + DEPTH, "stop999");
    chk("stop999 cnt", 64'(bus.thread_cnt), 64'h2);
    do_req(8'h10, 32'h180, 32'h0, 8'h11, 3, "dup180");
    chk("dup cnt", 64'(bus.thread_cnt), 64'h3);
    do_req(8'h12, 32'h180, 32'h0, 8'h13, 4, "stopdup");
    chk("stopdup slot1", 64'(dut.tbl[1].valid), 64'h0);
    chk("stopdup slot2", 64'(dut.tbl[2].valid), 64'h1);

    // Round-robin order; empty-table request must not move the pointer
    do_reset();
    sched_pulse(1'b0, 32'h0, "sched empty");
    do_req(8'h10, 32'h100, 32'h0, 8'h11, 3, "rA");
    do_req(8'h10, 32'h140, 32'h0, 8'h11, 3, "rB");
    do_req(8'h10, 32'h180, 32'h0, 8'h11, 3, "rC");
    sched_pulse(1'b1, 32'h100, "rr1");
    sched_pulse(1'b1, 32'h140, "rr2");
    sched_pulse(1'b1, 32'h180, "rr3");
    sched_pulse(1'b1, 32'h100, "rr4");

    // Held request: one allocation, ack held until release
    do_reset();
    bus.req_code = 8'h10;
    bus.req_addr = 32'h300;
    bus.req_data = 32'h0;
    repeat (10) tick();
    chk("hold ack", 64'(bus.ack_code), 64'h11);
    chk("hold cnt", 64'(bus.thread_cnt), 64'h1);
    chk("hold online", 64'(bus.disp_online), 64'h0);
    bus.req_code = 8'h00;
    tick();
    tick();
    chk("hold release ack", 64'(bus.ack_code), 64'h0);
    chk("hold release cnt", 64'(bus.thread_cnt), 64'h1);

    // Reset during SEARCH with the stop request still held
    do_reset();
    do_req(8'h10, 32'h100, 32'h0, 8'h11, 3, "pre");
    bus.req_code = 8'h12;
    bus.req_addr = 32'h999;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("midrst online", 64'(bus.disp_online), 64'h0);
    chk("midrst ack", 64'(bus.ack_code), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("postrst online", 64'(bus.disp_online), 64'h1);
    chk("postrst cnt", 64'(bus.thread_cnt), 64'h0);
    repeat (4) tick();
    chk("postrst no ack", 64'(bus.ack_code), 64'h0);
    chk("postrst no reprocess", 64'(bus.disp_online), 64'h1);
    bus.req_code = 8'h00;
    tick();
    sched_pulse(1'b0, 32'h0, "postrst sched");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/thread_dispatch_table.md
THREAD_DISPATCH_TABLE -- requirements
Module: thread_dispatch_table

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of thread slots (power of 2, 2..32).
REQ-002 SHALL have parameter ADDR_W, default 32, thread code/data address width.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port disp_online, output, 1, high when dispatcher is ready to accept thread messages.
REQ-006 SHALL have port req_code, input, 8, thread request message from the thread controller (00 = none).
REQ-007 SHALL have port req_addr, input, ADDR_W, thread code address.
REQ-008 SHALL have port req_data, input, ADDR_W, thread data address (0 = none).
REQ-009 SHALL have port ack_code, output, 8, reply message to the thread controller (00 = none).
REQ-010 SHALL have port sched_req, input, 1, scheduler asks for the next runnable thread.
REQ-011 SHALL have ports sched_valid (output, 1), sched_addr (output, ADDR_W) and sched_data (output, ADDR_W), carrying the selected thread.
REQ-012 SHALL have port thread_cnt, output, $clog2(DEPTH)+1, number of occupied slots.

Function
REQ-013 SHALL use message codes: FORK_THRD 8'h10, FORK_DONE 8'h11, STOP_THRD 8'h12, STOP_DONE 8'h13, NACK 8'h1F.
REQ-014 SHALL implement FSM IDLE -> LATCH -> (ALLOC | SEARCH) -> ACK -> WAIT_CLR -> IDLE.
REQ-015 SHALL, in IDLE with req_code FORK_THRD or STOP_THRD, latch req_code, req_addr and req_data and go to LATCH; it SHALL ignore any other code.
REQ-016 SHALL, for a fork, write {valid, addr, data} into the lowest-index free slot in ALLOC; if no slot is free it SHALL write nothing and reply NACK.
REQ-017 SHALL, for a stop, scan one slot per cycle from index 0 in SEARCH; on an addr match it SHALL clear valid and reply STOP_DONE; if no slot matches after DEPTH cycles it SHALL reply NACK.
REQ-018 SHALL hold ack_code in ACK and WAIT_CLR until req_code == 00, then drive ack_code 00 and return to IDLE (one request per handshake, no double processing).
REQ-019 SHALL give fork latency from req_code sampled to ack_code valid of exactly 3 cycles, and stop latency of 3+k cycles, where k is the matching index (DEPTH for a miss).
REQ-020 SHALL drive disp_online high only in IDLE and never during reset.
REQ-021 SHALL, on sched_req, select the next valid slot strictly after the last-issued index (round-robin, wrapping DEPTH-1 -> 0), register it, and assert sched_valid for exactly one cycle on the next clock.
REQ-022 SHALL, on sched_req with an empty table, keep sched_valid 0 and leave the round-robin pointer unchanged.
REQ-023 SHALL, when a table write/clear and a sched_req coincide, use the pre-update table contents for selection.
REQ-024 SHALL keep thread_cnt equal to the popcount of valid bits, updated the cycle after each ALLOC or SEARCH hit.
REQ-025 SHALL store duplicate fork addresses in separate slots; a stop clears only the lowest-index match.

Reset
REQ-026 SHALL, on rst, clear all valid bits, set the FSM to IDLE and the round-robin pointer to DEPTH-1, and drive ack_code 00, sched_valid 0, sched_addr/sched_data 0, thread_cnt 0 and disp_online 0.
REQ-027 SHALL, on rst mid-transaction, abandon the transaction without acknowledging it, and SHALL not clear the WAIT_CLR requirement.

Configuration
REQ-028 SHALL, with THREAD_DISPATCH_STATS_EN defined, add 16-bit saturating outputs fork_total, stop_total and nack_total, incremented on each FORK_DONE, STOP_DONE and NACK reply and cleared by rst; without the macro these ports and counters SHALL not exist.

Structure
REQ-029 SHALL take the message codes, the FSM state enum and the slot struct {valid, addr, data} from shared package thread_msg_pkg.
REQ-030 SHALL implement round-robin selection in sub-module thread_rr_arbiter (DEPTH-bit request vector, last index in; grant index and any-grant out).

Verification
REQ-031 SHALL cover: after reset, FORK_THRD addr 0x100 data 0x200 -> FORK_DONE 3 cycles later, thread_cnt 1, slot 0 valid.
REQ-032 SHALL cover: 9 forks with DEPTH 8 -> first 8 get FORK_DONE, the 9th gets NACK, thread_cnt stays 8.
REQ-033 SHALL cover: forks 0x100/0x140/0x180, then STOP_THRD 0x140 -> STOP_DONE after 4 cycles, thread_cnt 2; STOP_THRD 0x999 -> NACK after 3+DEPTH cycles.
REQ-034 SHALL cover: 3 threads, 4 sched_req pulses -> sched_addr sequence 0x100, 0x140, 0x180, 0x100; on an empty table sched_valid stays 0.
REQ-035 SHALL cover: req_code held at FORK_THRD for 10 cycles -> exactly one slot allocated, ack_code held until req_code returns to 00.
REQ-036 SHALL cover: rst asserted during SEARCH -> no ack, table empty, disp_online 0 during rst and 1 on the cycle after.
